// File: rtl/cube_edge_emitter.sv
// Cube edge emitter: snapshots the 8 projected cube vertices on start and
// streams the 12 cube edges as {x0,y0,x1,y1} line records with an
// approximate length, one edge per cycle under a valid/ready handshake.
module cube_edge_emitter #(
    parameter int unsigned LINE_BITS   = 7,
    parameter int unsigned THRESH_BITS = LINE_BITS + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [16*LINE_BITS-1:0]  vertices_i,
    output logic [4*LINE_BITS-1:0]   line_o,
    output logic [THRESH_BITS-1:0]   thresh_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    // Edge count is fixed by cube geometry, so it is not overridable.
    localparam int unsigned NUM_EDGES = 12;
    localparam logic [3:0]  LAST_IDX  = 4'(NUM_EDGES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

    state_e                    state_q;
    logic [3:0]                idx_q;
    logic [16*LINE_BITS-1:0]   verts_q;
    logic [4*LINE_BITS-1:0]    line_q;
    logic [THRESH_BITS-1:0]    thresh_q;
    logic                      valid_q;
    logic                      last_q;
    logic                      busy_q;
    logic                      done_q;

    logic [3:0]                sel_idx;
    logic [2:0]                va_idx;
    logic [2:0]                vb_idx;
    logic [2*LINE_BITS-1:0]    va;
    logic [2*LINE_BITS-1:0]    vb;
    logic [LINE_BITS-1:0]      x0, y0, x1, y1;
    logic [LINE_BITS-1:0]      dx, dy, mx, mn;
    logic [4*LINE_BITS-1:0]    nxt_line;
    logic [THRESH_BITS-1:0]    nxt_thresh;

    // Build the record for the edge that the output register loads next:
    // edge 0 while in LOAD, otherwise the one after the current index.
    always_comb begin
        sel_idx = (state_q == StLoad) ? 4'd0 : idx_q + 4'd1;
        // Groups of four edges flip vertex bit 0, then bit 1, then bit 2;
        // the lower-indexed vertex is always point 0.
        case (sel_idx[3:2])
            2'd0: begin
                va_idx = {sel_idx[1:0], 1'b0};
                vb_idx = {sel_idx[1:0], 1'b1};
            end
            2'd1: begin
                va_idx = {sel_idx[1], 1'b0, sel_idx[0]};
                vb_idx = {sel_idx[1], 1'b1, sel_idx[0]};
            end
            default: begin
                va_idx = {1'b0, sel_idx[1:0]};
                vb_idx = {1'b1, sel_idx[1:0]};
            end
        endcase
        va = verts_q[int'(va_idx) * 2 * LINE_BITS +: 2 * LINE_BITS];
        vb = verts_q[int'(vb_idx) * 2 * LINE_BITS +: 2 * LINE_BITS];
        x0 = va[2*LINE_BITS-1:LINE_BITS];
        y0 = va[LINE_BITS-1:0];
        x1 = vb[2*LINE_BITS-1:LINE_BITS];
        y1 = vb[LINE_BITS-1:0];
        dx = (x1 >= x0) ? x1 - x0 : x0 - x1;
        dy = (y1 >= y0) ? y1 - y0 : y0 - y1;
        mx = (dx >= dy) ? dx : dy;
        mn = (dx >= dy) ? dy : dx;
        nxt_line   = {x0, y0, x1, y1};
        // max + min/2 never exceeds 1.5x the coordinate range, so one extra bit suffices.
        nxt_thresh = THRESH_BITS'(mx) + THRESH_BITS'(mn >> 1);
    end

    // Frame sequencer with registered outputs and synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= 4'd0;
            verts_q  <= '0;
            line_q   <= '0;
            thresh_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        verts_q <= vertices_i;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    line_q   <= nxt_line;
                    thresh_q <= nxt_thresh;
                    valid_q  <= 1'b1;
                    last_q   <= 1'b0;
                    idx_q    <= 4'd0;
                    state_q  <= StEmit;
                end
                StEmit: begin
                    if (valid_q && ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            idx_q   <= 4'd0;
                            state_q <= StIdle;
                        end else begin
                            idx_q    <= idx_q + 4'd1;
                            line_q   <= nxt_line;
                            thresh_q <= nxt_thresh;
                            last_q   <= ((idx_q + 4'd1) == LAST_IDX);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign line_o   = line_q;
    assign thresh_o = thresh_q;
    assign valid_o  = valid_q;
    assign last_o   = last_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: doc/cube_edge_emitter.md
Name: cube_edge_emitter

Overview:
- Producer side of the line interface: takes the 8 projected cube vertices for a frame and emits the 12 cube edges as packed line records.
- Each record is a start point (x0,y0) and an end point (x1,y1), plus an approximate line length used as the consumer's threshold.
- Sits between the vertex projection stage and the line rasterizer/line buffer; valid/ready handshake, one edge per cycle when not stalled.

Parameters:
- LINE_BITS, 7, width of each coordinate.
- THRESH_BITS, LINE_BITS+1, width of the length/threshold output; wide enough that it never overflows.
- NUM_EDGES, 12, edges per frame; fixed, not for override.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  frame start pulse
- vertices_i  in  16*LINE_BITS  vertex i at [i*2*LINE_BITS +: 2*LINE_BITS], packed {x,y} (x in upper half)
- line_o  out  4*LINE_BITS  packed {x0,y0,x1,y1}, MSB first
- thresh_o  out  THRESH_BITS  approximate length of line_o
- valid_o  out  1  line_o/thresh_o/last_o valid
- ready_i  in  1  consumer accepts
- last_o  out  1  high with edge 11
- busy_o  out  1  high from the cycle after an accepted start until the cycle after the final transfer
- done_o  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (rst_n=0 at a clk edge) applies in any state, including mid-frame. Result: state IDLE, edge index 0, and all outputs 0 (valid_o, last_o, busy_o, done_o, line_o, thresh_o).
- FSM states: IDLE, LOAD, EMIT.
- IDLE: if start_i=1, snapshot vertices_i into an internal register and go to LOAD; busy_o=1 next cycle. Otherwise stay in IDLE.
- LOAD: compute edge 0 from the snapshot into the output register, set valid_o=1, go to EMIT.
- Latency: start_i sampled at edge N gives valid_o=1 after edge N+1.
- EMIT: transfer occurs when valid_o && ready_i at a clk edge.
  - On a transfer with index<11: index+1, and the output register loads the next edge at the same edge. Throughput is back-to-back, 1 edge/cycle.
  - On a transfer with index=11: valid_o=0, last_o=0, busy_o=0, done_o=1 for one cycle, state IDLE.
- Stall: while valid_o=1 and ready_i=0, line_o, thresh_o and last_o hold stable. valid_o never drops without a transfer.
- start_i while not in IDLE is ignored. Vertex changes after the snapshot do not affect the current frame.
- start_i in the same cycle as done_o (state already IDLE): accepted normally.
- Edge order is fixed. Vertex index bits are (b0,b1,b2); edges join vertices differing in one bit, lower index always at point 0.
  - edges 0-3: 0-1, 2-3, 4-5, 6-7
  - edges 4-7: 0-2, 1-3, 4-6, 5-7
  - edges 8-11: 0-4, 1-5, 2-6, 3-7
- Length arithmetic:
  - dx=|x1-x0|, dy=|y1-y0|, unsigned LINE_BITS each.
  - thresh = max(dx,dy) + (min(dx,dy)>>1), computed at THRESH_BITS width with no saturation.
  - Maximum is 127+63=190 for LINE_BITS=7.
- Degenerate edge (x0=x1 and y0=y1): emitted normally with thresh=0.

Test Plan:
- Basic frame, ready_i tied 1. Vertices v0=(10,10), v1=(30,10), v2=(10,30), v3=(30,30), v4=(15,15), v5=(35,15), v6=(15,35), v7=(35,35); start_i at cycle 0.
  - valid_o rises at cycle 2, then 12 consecutive transfers.
  - edge0 = {10,10,30,10}, thresh 20.
  - edge4 = {10,10,10,30}, thresh 20.
  - edge8 = {10,10,15,15}, thresh 7.
  - last_o only on edge11 = {30,30,35,35}; done_o pulses once; busy_o then 0.
- Backpressure: same vertices, ready_i random 50% -> exactly 12 transfers in the same order as the basic frame; outputs stable during every ready_i=0 cycle.
- Extremes: v0=(0,0), v1=(127,127), v2=(127,0), others (0,0) -> edge0 thresh 190, edge4 thresh 127 (dx=127, dy=0).
- Edge 3 is v6-v7, both (0,0) in this vertex set -> thresh 0, still emitted.
- start_i pulsed at mid-frame index 5, with vertices_i changed -> ignored. Remaining edges use the original snapshot; total transfers 12.
- rst_n=0 for one cycle at index 7, with ready_i held 0 -> next cycle valid_o=0, busy_o=0, line_o=0. A new start_i then produces edge0 first after 2 cycles.
